// File: rtl/color_pkg.sv
// Shared palette definitions for the colour encoder and decoder.
package color_pkg;

  typedef logic [11:0] rgb12_t;

  localparam logic [2:0] WHITE  = 3'b000;
  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] BLUE   = 3'b010;
  localparam logic [2:0] GREEN  = 3'b011;
  localparam logic [2:0] YELLOW = 3'b100;
  localparam logic [2:0] PURPLE = 3'b101;
  localparam logic [2:0] ERASE  = 3'b111;

  localparam rgb12_t WHITE_RGB  = 12'hFFF;
  localparam rgb12_t RED_RGB    = 12'hF00;
  localparam rgb12_t GREEN_RGB  = 12'h0F0;
  localparam rgb12_t BLUE_RGB   = 12'h00F;
  localparam rgb12_t BLACK_RGB  = 12'h000;
  localparam rgb12_t BRUSH_RGB  = {4'hF, 4'h8, 4'h0};

  // Per-channel threshold bits {rb, gb, bb}.
  function automatic logic [2:0] thresh3(input rgb12_t p, input logic [3:0] th);
    return {p[11:8] >= th, p[7:4] >= th, p[3:0] >= th};
  endfunction

endpackage

// File: rtl/color_classify.sv
// Combinational map from thresholded {rb,gb,bb} to a palette code.
module color_classify
  import color_pkg::*;
#(
  parameter logic [2:0] CYAN_CODE = 3'b000
) (
  input  logic [2:0] i_bits,
  output logic [2:0] o_code
);

  always_comb begin
    o_code = ERASE;
    case (i_bits)
      3'b000: o_code = ERASE;
      3'b100: o_code = RED;
      3'b001: o_code = BLUE;
      3'b010: o_code = GREEN;
      3'b110: o_code = YELLOW;
      3'b101: o_code = PURPLE;
      3'b111: o_code = WHITE;
      3'b011: o_code = CYAN_CODE;
      default: o_code = ERASE;
    endcase
  end

endmodule

// File: rtl/color_encode.sv
// RGB444 -> palette code encoder, 2-stage valid/ready pipe with frame addressing.
module color_encode
  import color_pkg::*;
#(
  parameter int          H_PIXELS  = 640,
  parameter int          V_PIXELS  = 480,
  parameter logic [3:0]  THRESH    = 4'h8,
  parameter logic [2:0]  CYAN_CODE = 3'b000,
  localparam int         AW        = $clog2(H_PIXELS * V_PIXELS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_r,
  input  logic [3:0]    in_g,
  input  logic [3:0]    in_b,
  input  logic          in_sof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_code,
  output logic          out_brush,
  output logic [AW-1:0] out_addr,
  output logic          out_last
);

  localparam logic [AW-1:0] LAST = AW'(H_PIXELS * V_PIXELS - 1);

  logic          r_rst_done;
  logic          r_s1_valid;
  logic [2:0]    r_s1_bits;
  logic          r_s1_brush;
  logic [AW-1:0] r_s1_addr;
  logic [AW-1:0] r_cnt;

  logic          w_adv1, w_adv2, w_accept;
  rgb12_t        w_pix;
  logic [AW-1:0] w_addr, w_cnt_nxt;
  logic [2:0]    w_code;

  assign w_adv2   = !out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  // Held low during reset and the first edge after it.
  assign in_ready = w_adv1 && r_rst_done;
  assign w_accept = in_valid && in_ready;

  assign w_pix     = {in_r, in_g, in_b};
  assign w_addr    = in_sof ? '0 : r_cnt;
  assign w_cnt_nxt = (w_addr == LAST) ? '0 : w_addr + AW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) r_rst_done <= 1'b0;
    else          r_rst_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_bits  <= '0;
      r_s1_brush <= 1'b0;
      r_s1_addr  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) r_cnt <= w_cnt_nxt;
      if (w_adv1) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_bits  <= thresh3(w_pix, THRESH);
          r_s1_brush <= (w_pix == BRUSH_RGB);
          r_s1_addr  <= w_addr;
        end
      end
    end
  end

  color_classify #(.CYAN_CODE(CYAN_CODE)) u_classify (
    .i_bits (r_s1_bits),
    .o_code (w_code)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_brush <= 1'b0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_code  <= w_code;
        out_brush <= r_s1_brush;
        out_addr  <= r_s1_addr;
        out_last  <= (r_s1_addr == LAST);
      end
    end
  end

endmodule

// File: tb/tb_color_encode.sv
// Scoreboard bench for color_encode on a 4x2 frame with a distinct cyan code.
module tb_color_encode;

  localparam int          H    = 4;
  localparam int          V    = 2;
  localparam int          TOT  = H * V;
  localparam int          AW   = $clog2(TOT);
  localparam logic [2:0]  CYAN = 3'b110;

  logic          clk, reset_n;
  logic          in_valid, in_ready, in_sof;
  logic [3:0]    in_r, in_g, in_b;
  logic          out_valid, out_ready, out_brush, out_last;
  logic [2:0]    out_code;
  logic [AW-1:0] out_addr;

  color_encode #(.H_PIXELS(H), .V_PIXELS(V), .THRESH(4'h8), .CYAN_CODE(CYAN)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_brush(out_brush),
    .out_addr(out_addr), .out_last(out_last)
  );

  typedef struct {logic [2:0] code; logic brush; int addr;} exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, cyc = 0, mcnt = 0;
  int lat_state = 0, lat_cyc = 0, stall_run = 0, drain_cnt = 0;
  bit rst_low = 0, rst_ph = 0, hold = 0;
  bit rnd_bp = 0, want_ready = 1, drain_req = 0, drain_done = 0;
  logic [AW+4:0] h_vec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference classification straight from the colour rules.
  function automatic logic [2:0] ref_code(input logic [3:0] r, g, b);
    bit hr = (r >= 8), hg = (g >= 8), hb = (b >= 8);
    int n = int'(hr) + int'(hg) + int'(hb);
    if (n == 0) return 3'b111;
    if (n == 3) return 3'b000;
    if (n == 1) return hr ? 3'b001 : (hb ? 3'b010 : 3'b011);
    if (!hb)    return 3'b100;
    if (!hg)    return 3'b101;
    return CYAN;
  endfunction

  always begin
    @(negedge clk); #1;
    out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : want_ready;
  end

  // Monitor/scoreboard: samples 1 time unit before each rising edge.
  always begin
    exp_t e;
    @(negedge clk); #4; cyc++;
    if (!reset_n) begin
      if (rst_low) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
      end
      rst_low = 1; rst_ph = 1; hold = 0; stall_run = 0;
      q.delete(); mcnt = 0;
    end else begin
      rst_low = 0;
      if (rst_ph) begin
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_code", out_code, 0);
        chk("post_rst_brush", out_brush, 0);
        chk("post_rst_addr", out_addr, 0);
        chk("post_rst_last", out_last, 0);
        rst_ph = 0;
      end
      if (hold) chk("hold_stable", {out_code, out_brush, out_addr, out_last}, h_vec);
      if (out_valid && !out_ready && in_valid) begin
        if (stall_run >= 1) chk("stall_in_ready", in_ready, 0);
        stall_run++;
      end else stall_run = 0;
      if (out_valid && lat_state == 1) begin
        chk("first_latency", cyc - lat_cyc, 2);
        lat_state = 2;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got addr %0d expected none", out_addr);
        end else begin
          e = q.pop_front();
          chk("code", out_code, e.code);
          chk("brush", out_brush, e.brush);
          chk("addr", out_addr, e.addr);
          chk("last", out_last, e.addr == TOT - 1);
        end
      end
      if (in_valid && in_ready) begin
        e.code  = ref_code(in_r, in_g, in_b);
        e.brush = ({in_r, in_g, in_b} == 12'hF80);
        e.addr  = in_sof ? 0 : mcnt;
        mcnt    = (e.addr + 1) % TOT;
        q.push_back(e);
        if (lat_state == 0) begin lat_cyc = cyc; lat_state = 1; end
      end
      hold  = out_valid && !out_ready;
      h_vec = {out_code, out_brush, out_addr, out_last};
    end
    if (drain_req && !drain_done) begin
      drain_cnt++;
      if (q.size() == 0 || drain_cnt > 60) begin
        chk("drain_empty", q.size(), 0);
        drain_done = 1;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [11:0] px, input logic sof);
    logic acc;
    int t = 0;
    in_valid = 1'b1; {in_r, in_g, in_b} = px; in_sof = sof;
    forever begin
      #4; acc = in_ready;
      @(negedge clk);
      if (acc) break;
      if (++t > 200) begin
        $display("FAIL send_timeout: got no in_ready expected accept within 200 cycles");
        $fatal(1);
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  logic [11:0] t1_px [8] = '{12'hF00, 12'h00F, 12'h0F0, 12'hFF0,
                             12'hF0F, 12'hFFF, 12'h000, 12'h0FF};
  logic [11:0] t2_px [4] = '{12'hF80, 12'hF70, 12'h777, 12'h888};

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) send(t1_px[i], i == 0);
    for (int i = 0; i < 4; i++) send(t2_px[i], 1'b0);

    fork
      for (int i = 0; i < 10; i++) send(12'(i * 12'h135), 1'b0);
      begin
        repeat (3) @(negedge clk);
        want_ready = 0;
        repeat (5) @(negedge clk);
        want_ready = 1;
      end
    join
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) send(t1_px[i % 8], i == 0);
    for (int i = 0; i < 5; i++)  send(t2_px[i % 4], i == 3);
    repeat (4) @(negedge clk);

    want_ready = 0;
    send(12'hF00, 1'b0);
    send(12'h0F0, 1'b0);
    reset_n = 1'b0; want_ready = 1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) send(t1_px[i + 3], 1'b0);

    rnd_bp = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send(12'($urandom), $urandom_range(0, 15) == 0);
    end
    rnd_bp = 0;
    drain_req = 1;
    for (int t = 0; t < 100 && !drain_done; t++) @(negedge clk);
    if (!drain_done) begin
      $display("FAIL drain_timeout: got no drain result expected one within 100 cycles");
      $fatal(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
